cache_nway_wt: RTL and testbench

Parametrised N-way set-associative, write-through, word-line cache between the core's load/store port and main memory. It adds explicit request/ready handshakes on both sides, a synchronous reset that invalidates all lines, first-invalid/round-robin victim selection, and optional hit/miss statistics.

---
 rtl/cache_nway_wt_if.sv | 37 +++
 rtl/cache_nway_wt.sv | 202 ++++++++++++++++++++
 tb/tb_cache_nway_wt.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_wt_if.sv
// cache_nway_wt_if -- CPU-side and memory-side handshake bundle of cache_nway_wt.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : load/store request, held until cpu_ready
//   cpu_rdata/cpu_ready               : load data + one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_rdata/mem_ack                 : memory read data + completion
// Modports: slave = the cache, master = the core plus memory environment.
interface cache_nway_wt_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_nway_wt.sv
// cache_nway_wt -- N-way set-associative, write-through, one-word-per-line cache.
//   clk, rst          : clock, synchronous active-high reset (invalidates all lines)
//   bus (slave)       : CPU request/ready port and memory request/ack port
//   hit_count         : lookups that hit (stats build only, else 0)
//   miss_count        : lookups that missed (stats build only, else 0)
// Optional feature macro: CACHE_STATS_EN builds saturating hit/miss counters.
// Reads allocate on miss (first invalid way, else the set's round-robin way);
// writes always go to memory, update the line on hit and never allocate.
module cache_nway_wt #(
  parameter int WAYS   = 4,
  parameter int SETS   = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  cache_nway_wt_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int WRD_W = ADDR_W - 2;
  localparam int TAG_W = WRD_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_RD, MEM_WR} state_t;
  state_t state, state_nxt;

  // Latched request; byte offset is dropped at capture.
  logic [WRD_W-1:0]  req_word;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  assign idx = req_word[IDX_W-1:0];
  assign tag = req_word[WRD_W-1:IDX_W];

  // Line state: valid/rr are reset, tag/data arrays are not.
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS];

  // Parallel tag compare across all ways of the selected set.
  logic [WAYS-1:0] hit_vec;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_q[idx][w] && (tag_mem[w][idx] == tag);
  end

  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_way;
  logic             all_valid;
  logic             found_inv;
  assign any_hit   = |hit_vec;
  assign all_valid = &valid_q[idx];

  // Only one way can hit (fills only target a missing tag), so a plain
  // priority encode is enough.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  // Victim: lowest-index invalid way, else the round-robin pointer.
  always_comb begin
    vic_way   = rr_q[idx];
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!found_inv && !valid_q[idx][w]) begin
        vic_way   = WAY_W'(w);
        found_inv = 1'b1;
      end
  end

  // Control strobes, one per FSM event.
  logic accept, rd_hit, wr_hit, go_rd, go_wr, done_rd, done_wr;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_hit    = 1'b0;
    wr_hit    = 1'b0;
    go_rd     = 1'b0;
    go_wr     = 1'b0;
    done_rd   = 1'b0;
    done_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        // The completed request is still held during its ready cycle; skip it.
        if (bus.cpu_req && !bus.cpu_ready) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_we) begin
          wr_hit    = any_hit;
          go_wr     = 1'b1;
          state_nxt = MEM_WR;
        end else if (any_hit) begin
          rd_hit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          go_rd     = 1'b1;
          state_nxt = MEM_RD;
        end
      end
      MEM_RD: begin
        if (bus.mem_req && bus.mem_ack) begin
          done_rd   = 1'b1;
          state_nxt = IDLE;
        end
      end
      MEM_WR: begin
        if (bus.mem_req && bus.mem_ack) begin
          done_wr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_word  <= bus.cpu_addr[ADDR_W-1:2];
      req_we    <= bus.cpu_we;
      req_wdata <= bus.cpu_wdata;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.cpu_ready <= rd_hit | done_rd | done_wr;
      if (rd_hit)  bus.cpu_rdata <= data_mem[hit_way][idx];
      if (done_rd) bus.cpu_rdata <= bus.mem_rdata;
      if (go_rd || go_wr) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= go_wr;
        bus.mem_addr <= {req_word, 2'b00};
        if (go_wr) bus.mem_wdata <= req_wdata;
      end
      if (done_rd || done_wr) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
      end
    end
  end

  // Valid bits and RR pointers; the pointer only advances when a valid line
  // is evicted.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (done_rd) begin
      valid_q[idx][vic_way] <= 1'b1;
      if (all_valid) rr_q[idx] <= rr_q[idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (done_rd) begin
      tag_mem[vic_way][idx]  <= tag;
      data_mem[vic_way][idx] <= bus.mem_rdata;
    end
    if (wr_hit) data_mem[hit_way][idx] <= req_wdata;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (any_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_nway_wt.sv
// Testbench for cache_nway_wt (WAYS=4, SETS=64): directed test-plan steps
// followed by random loads/stores, checked against a set/way reference model
// and a word-addressed main memory held in an associative array.
module tb_cache_nway_wt;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count, miss_count;
  always #5 clk = ~clk;

  cache_nway_wt_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_nway_wt #(.WAYS(4), .SETS(64), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model.
  bit          m_valid [64][4];
  logic [23:0] m_tag   [64][4];
  logic [31:0] m_data  [64][4];
  int          m_rr    [64];
  int          m_hits, m_misses;
  logic [31:0] mainmem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mainmem.exists(a)) mainmem[a] = $urandom;
    return mainmem[a];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"}, hit_count, m_hits);
    chk({tag, "_misses"}, miss_count, m_misses);
`else
    chk({tag, "_hits"}, hit_count, 32'd0);
    chk({tag, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One CPU transaction with a memory responder that waits 'waits' cycles
  // before acking. Predicts hit/miss, data, memory traffic and latency.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, output logic [31:0] rdata, output bit used);
    int          s, hw, lat, wcnt, exp_lat;
    logic [23:0] tg;
    logic [31:0] waddr, exp_rdata;
    bit          done, exp_mem;
    s     = int'(addr[7:2]);
    tg    = addr[31:8];
    waddr = {addr[31:2], 2'b00};
    hw    = -1;
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    exp_mem   = we || (hw < 0);
    exp_lat   = exp_mem ? 3 + waits : 2;
    exp_rdata = (hw >= 0) ? m_data[s][hw] : mem_word(waddr);
    rdata = '0; used = 1'b0; done = 1'b0; lat = 0; wcnt = 0;

    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = {addr[31:2], 2'($urandom)};
    bus.cpu_wdata = wdata;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) begin
        done = 1'b1;
        rdata = bus.cpu_rdata;
        bus.mem_ack = 1'b0;
        chk("mem_req_fall", bus.mem_req, 1'b0);
      end else if (bus.mem_req) begin
        if (!used) begin
          used = 1'b1;
          chk("mem_we", bus.mem_we, we);
          chk("mem_addr", bus.mem_addr, waddr);
          if (we) chk("mem_wdata", bus.mem_wdata, wdata);
        end
        bus.mem_ack   = (wcnt == waits);
        bus.mem_rdata = (wcnt == waits && !we) ? mem_word(waddr) : $urandom;
        wcnt++;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    if (!done) begin
      chk("timeout", 32'(lat), 32'd0);
      bus.cpu_req = 1'b0;
      bus.mem_ack = 1'b0;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("mem_used", 32'(used), 32'(exp_mem));
    if (!we) chk("rdata", rdata, exp_rdata);

    // Core drops the request only after the edge that ends the ready cycle.
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;

    // Model update.
    if (hw >= 0) m_hits++; else m_misses++;
    if (we) begin
      mainmem[waddr] = wdata;
      if (hw >= 0) m_data[s][hw] = wdata;
    end else if (hw < 0) begin
      int v;
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 4;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = tg;
      m_data[s][v]  = exp_rdata;
    end

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_ready", bus.cpu_ready, 1'b0);
      chk("idle_mem_req", bus.mem_req, 1'b0);
    end
    chk_stats("stats");
  endtask

  initial begin
    logic [31:0] r, w2, a;
    bit          u;
    int          n;

    do_reset();
    chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk_stats("rst");

    // Read miss, then hit.
    mainmem[32'h0000_1000] = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_1000, '0, 3, r, u);
    chk("tp_miss_data", r, 32'hDEAD_BEEF);
    chk("tp_miss_used", 32'(u), 32'd1);
    access(1'b0, 32'h0000_1000, '0, 0, r, u);
    chk("tp_hit_data", r, 32'hDEAD_BEEF);
    chk("tp_hit_used", 32'(u), 32'd0);

    // Write hit goes through to memory and updates the line.
    access(1'b1, 32'h0000_1000, 32'h1234_5678, 1, r, u);
    access(1'b0, 32'h0000_1000, '0, 0, r, u);
    chk("tp_wr_hit_data", r, 32'h1234_5678);
    chk("tp_wr_hit_used", 32'(u), 32'd0);

    // Write miss does not allocate.
    w2 = 32'hA5A5_0F0F;
    access(1'b1, 32'h0000_2000, w2, 0, r, u);
    access(1'b0, 32'h0000_2000, '0, 2, r, u);
    chk("tp_wr_miss_used", 32'(u), 32'd1);
    chk("tp_wr_miss_data", r, w2);

    // Fill all four ways of set 0, then evict way 0.
    do_reset();
    for (int x = 1; x <= 5; x++) begin
      access(1'b0, 32'(x) << 12, '0, x % 3, r, u);
      chk("tp_fill_used", 32'(u), 32'd1);
    end
    access(1'b0, 32'h0000_2000, '0, 0, r, u);
    chk("tp_way1_kept", 32'(u), 32'd0);
    access(1'b0, 32'h0000_1000, '0, 1, r, u);
    chk("tp_evicted_miss", 32'(u), 32'd1);

    // Reset while waiting in MEM_RD.
    access(1'b0, 32'h0000_3000, '0, 0, r, u);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_7000;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_req_seen", bus.mem_req, 1'b1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_req", bus.mem_req, 1'b0);
    chk("rstmid_ready", bus.cpu_ready, 1'b0);
    rst = 1'b0;
    model_reset();
    access(1'b0, 32'h0000_3000, '0, 0, r, u);
    chk("rstmid_miss", 32'(u), 32'd1);

    // Random traffic over a small tag/set pool to force hits and evictions.
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 2)) << 2);
      access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 3), r, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
